// File: rtl/sp_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_sweep_pkg
//  Description : Shared types and helpers for the S-parameter sweep sequencer:
//                the sweep state enum, default widths and the port-count clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package sp_sweep_pkg;

    localparam int DEF_FREQ_W    = 32;
    localparam int DEF_IDX_W     = 16;
    localparam int DEF_MAX_PORTS = 4;
    localparam int DEF_PORT_W    = 3;
    localparam int DEF_SETTLE_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET     = 3'd1,
        S_SETTLE  = 3'd2,
        S_MEASURE = 3'd3,
        S_NEXT    = 3'd4,
        S_FINISH  = 3'd5
    } sweep_state_t;

    // A request for zero ports still excites one port; more than the fabric
    // supports is limited to the highest port number.
    function automatic int clamp_ports(input int requested, input int max_ports);
        if (requested < 1) begin
            return 1;
        end
        if (requested > max_ports) begin
            return max_ports;
        end
        return requested;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_freq_accum.sv
`default_nettype none
// ============================================================================
//  Module      : sp_freq_accum
//  Description : Source frequency accumulator. Loads a start value, adds the
//                step on request and keeps a sticky flag for any carry-out.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                load_i/load_val_i - load accumulator (start or reload)
//                clr_ovf_i       - clear the sticky wrap flag
//                step_i/step_val_i - add one frequency step
//                freq_o, ovf_o   - current frequency, sticky wrap flag
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_freq_accum
    import sp_sweep_pkg::*;
#(
    parameter int FREQ_W = DEF_FREQ_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [FREQ_W-1:0] load_val_i,
    input  logic              clr_ovf_i,
    input  logic              step_i,
    input  logic [FREQ_W-1:0] step_val_i,
    output logic [FREQ_W-1:0] freq_o,
    output logic              ovf_o
);

    logic [FREQ_W-1:0] freq_q;
    logic              ovf_q;
    logic [FREQ_W:0]   sum_w;

    // One extra bit captures the carry-out of the modular add.
    assign sum_w = {1'b0, freq_q} + {1'b0, step_val_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (load_i) begin
                freq_q <= load_val_i;
            end else if (step_i) begin
                freq_q <= sum_w[FREQ_W-1:0];
            end
            if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end else if (step_i && !load_i && sum_w[FREQ_W]) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign freq_o = freq_q;
    assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/sp_sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sp_sweep_sequencer
//  Description : Multi-port S-parameter sweep sequencer. Walks a frequency
//                grid and a set of ports (either loop order), driving the
//                source, waiting a settle time and handing each step to the
//                receiver through a meas_req/meas_ack handshake.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                start, abort                - sweep control
//                f_start, f_step, n_points,
//                n_ports, settle_cycles      - sweep configuration (latched)
//                src_freq, src_port, src_en  - source control
//                meas_req / meas_ack         - receiver handshake
//                point_idx, busy, done,
//                aborted, freq_ovf           - status
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_sweep_sequencer
    import sp_sweep_pkg::*;
#(
    parameter int FREQ_W     = DEF_FREQ_W,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int MAX_PORTS  = DEF_MAX_PORTS,
    parameter int PORT_W     = DEF_PORT_W,
    parameter int SETTLE_W   = DEF_SETTLE_W,
    parameter bit FREQ_OUTER = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [FREQ_W-1:0]   f_start,
    input  logic [FREQ_W-1:0]   f_step,
    input  logic [IDX_W-1:0]    n_points,
    input  logic [PORT_W-1:0]   n_ports,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic [FREQ_W-1:0]   src_freq,
    output logic [PORT_W-1:0]   src_port,
    output logic                src_en,
    output logic                meas_req,
    input  logic                meas_ack,
    output logic [IDX_W-1:0]    point_idx,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                freq_ovf
);

    sweep_state_t        state_q, state_d;
    logic [FREQ_W-1:0]   fstart_q, fstart_d;
    logic [FREQ_W-1:0]   fstep_q, fstep_d;
    logic [IDX_W-1:0]    npts_q, npts_d;
    logic [IDX_W-1:0]    pt_q, pt_d;
    logic [PORT_W-1:0]   nports_q, nports_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic                done_q, aborted_q;

    logic                acc_clr, acc_reload, acc_step;
    logic                last_port, last_pt, in_step;

    always_comb begin
        state_d    = state_q;
        fstart_d   = fstart_q;
        fstep_d    = fstep_q;
        npts_d     = npts_q;
        pt_d       = pt_q;
        nports_d   = nports_q;
        port_d     = port_q;
        settle_d   = settle_q;
        cnt_d      = cnt_q;
        acc_clr    = 1'b0;
        acc_reload = 1'b0;
        acc_step   = 1'b0;
        last_port  = (port_q == nports_q);
        last_pt    = (pt_q == npts_q - IDX_W'(1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fstart_d = f_start;
                    fstep_d  = f_step;
                    npts_d   = n_points;
                    nports_d = PORT_W'(clamp_ports(int'(n_ports), MAX_PORTS));
                    settle_d = settle_cycles;
                    pt_d     = '0;
                    port_d   = PORT_W'(1);
                    acc_clr  = 1'b1;
                    state_d  = (n_points == '0) ? S_FINISH : S_SET;
                end
            end
            S_SET: begin
                if (settle_q == '0) begin
                    state_d = S_MEASURE;
                end else begin
                    // Counter runs settle-1 .. 0, giving exactly settle cycles.
                    cnt_d   = settle_q - SETTLE_W'(1);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_MEASURE;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            S_MEASURE: begin
                if (meas_ack) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_port && last_pt) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_SET;
                    if (FREQ_OUTER) begin
                        if (!last_port) begin
                            port_d = port_q + PORT_W'(1);
                        end else begin
                            port_d   = PORT_W'(1);
                            pt_d     = pt_q + IDX_W'(1);
                            acc_step = 1'b1;
                        end
                    end else begin
                        if (!last_pt) begin
                            pt_d     = pt_q + IDX_W'(1);
                            acc_step = 1'b1;
                        end else begin
                            // New port restarts the frequency grid.
                            pt_d       = '0;
                            port_d     = port_q + PORT_W'(1);
                            acc_reload = 1'b1;
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any step/reload decided above.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            acc_step   = 1'b0;
            acc_reload = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            fstart_q  <= '0;
            fstep_q   <= '0;
            npts_q    <= '0;
            pt_q      <= '0;
            nports_q  <= '0;
            port_q    <= '0;
            settle_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fstart_q  <= fstart_d;
            fstep_q   <= fstep_d;
            npts_q    <= npts_d;
            pt_q      <= pt_d;
            nports_q  <= nports_d;
            port_q    <= port_d;
            settle_q  <= settle_d;
            cnt_q     <= cnt_d;
            done_q    <= (state_q == S_FINISH) && !abort;
            aborted_q <= abort && (state_q != S_IDLE);
        end
    end

    sp_freq_accum #(
        .FREQ_W (FREQ_W)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (acc_clr | acc_reload),
        .load_val_i (acc_clr ? f_start : fstart_q),
        .clr_ovf_i  (acc_clr),
        .step_i     (acc_step),
        .step_val_i (fstep_q),
        .freq_o     (src_freq),
        .ovf_o      (freq_ovf)
    );

    assign in_step   = (state_q == S_SET) || (state_q == S_SETTLE) ||
                       (state_q == S_MEASURE) || (state_q == S_NEXT);
    assign busy      = in_step;
    assign src_en    = in_step;
    assign src_port  = in_step ? port_q : '0;
    assign meas_req  = (state_q == S_MEASURE);
    assign point_idx = pt_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_sweep_sequencer
//  Description : Self-checking bench. Two sequencers (frequency-outer and
//                port-outer) run in lockstep on shared stimulus; the expected
//                step order, frequencies and wrap flag are computed from the
//                sweep index with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_sweep_sequencer;

    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        meas_ack = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_step = '0;
    logic [15:0] n_points = '0;
    logic [2:0]  n_ports = '0;
    logic [15:0] settle_cycles = '0;

    logic [31:0] a_src_freq, b_src_freq;
    logic [2:0]  a_src_port, b_src_port;
    logic [15:0] a_point_idx, b_point_idx;
    logic        a_src_en, a_meas_req, a_busy, a_done, a_aborted, a_freq_ovf;
    logic        b_src_en, b_meas_req, b_busy, b_done, b_aborted, b_freq_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sp_sweep_sequencer #(.FREQ_OUTER(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .n_points(n_points), .n_ports(n_ports),
        .settle_cycles(settle_cycles), .src_freq(a_src_freq), .src_port(a_src_port),
        .src_en(a_src_en), .meas_req(a_meas_req), .meas_ack(meas_ack),
        .point_idx(a_point_idx), .busy(a_busy), .done(a_done), .aborted(a_aborted),
        .freq_ovf(a_freq_ovf)
    );

    sp_sweep_sequencer #(.FREQ_OUTER(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .n_points(n_points), .n_ports(n_ports),
        .settle_cycles(settle_cycles), .src_freq(b_src_freq), .src_port(b_src_port),
        .src_en(b_src_en), .meas_req(b_meas_req), .meas_ack(meas_ack),
        .point_idx(b_point_idx), .busy(b_busy), .done(b_done), .aborted(b_aborted),
        .freq_ovf(b_freq_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep cycle-by-cycle against the index-based model.
    // abort_k >= 0 aborts in settle cycle abort_dly of step abort_k.
    task automatic run_sweep(input string nm, input logic [31:0] fs, input logic [31:0] fst,
                             input int np, input int npo, input int st, input int ack_lo,
                             input int abort_k, input int abort_dly);
        int          eff, total, ai, ap, bi, bp, bmax;
        logic [31:0] fa, fb;
        logic        eov_a, eov_b;
        eff   = (npo < 1) ? 1 : ((npo > MAXP) ? MAXP : npo);
        total = np * eff;
        f_start = fs; f_step = fst; n_points = 16'(np); n_ports = 3'(npo);
        settle_cycles = 16'(st);
        start = 1'b1;
        tick();
        start = 1'b0;
        // Configuration must be latched; scramble the inputs from here on.
        f_start = $urandom; f_step = $urandom; n_points = 16'($urandom_range(1, 9));
        n_ports = 3'($urandom_range(0, 7)); settle_cycles = 16'($urandom_range(0, 9));
        for (int k = 0; k < total; k++) begin
            ai   = k / eff;  ap = k % eff + 1;
            bi   = k % np;   bp = k / np + 1;
            bmax = (k >= np) ? np - 1 : bi;
            fa   = fs + 32'(ai) * fst;
            fb   = fs + 32'(bi) * fst;
            eov_a = (64'(fs) + 64'(ai) * 64'(fst)) > 64'hFFFF_FFFF;
            eov_b = (64'(fs) + 64'(bmax) * 64'(fst)) > 64'hFFFF_FFFF;
            n_cmp++;
            if ({a_src_en, a_busy, a_meas_req, a_done, a_aborted, a_freq_ovf, a_src_port, a_point_idx, a_src_freq}
                !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, eov_a, 3'(ap), 16'(ai), fa}) begin
                n_err++;
                $display("FAIL %s A set k=%0d: got en=%b busy=%b req=%b done=%b ab=%b ovf=%b port=%0d idx=%0d f=%h, want en=1 busy=1 req=0 done=0 ab=0 ovf=%b port=%0d idx=%0d f=%h",
                         nm, k, a_src_en, a_busy, a_meas_req, a_done, a_aborted, a_freq_ovf, a_src_port, a_point_idx, a_src_freq, eov_a, ap, ai, fa);
            end
            n_cmp++;
            if ({b_src_en, b_busy, b_meas_req, b_done, b_aborted, b_freq_ovf, b_src_port, b_point_idx, b_src_freq}
                !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, eov_b, 3'(bp), 16'(bi), fb}) begin
                n_err++;
                $display("FAIL %s B set k=%0d: got en=%b busy=%b req=%b done=%b ab=%b ovf=%b port=%0d idx=%0d f=%h, want en=1 busy=1 req=0 done=0 ab=0 ovf=%b port=%0d idx=%0d f=%h",
                         nm, k, b_src_en, b_busy, b_meas_req, b_done, b_aborted, b_freq_ovf, b_src_port, b_point_idx, b_src_freq, eov_b, bp, bi, fb);
            end
            for (int j = 0; j < st; j++) begin
                meas_ack = 1'($urandom_range(0, 1));
                tick();
                n_cmp++;
                if ({a_meas_req, b_meas_req, a_src_en, b_src_en} !== 4'b0011) begin
                    n_err++;
                    $display("FAIL %s settle k=%0d j=%0d: got reqA=%b reqB=%b enA=%b enB=%b, want req=0 en=1",
                             nm, k, j, a_meas_req, b_meas_req, a_src_en, b_src_en);
                end
                if (k == abort_k && j == abort_dly) begin
                    meas_ack = 1'b0;
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    n_cmp++;
                    if ({a_aborted, a_src_en, a_meas_req, a_busy, a_src_port, a_done,
                         b_aborted, b_src_en, b_meas_req, b_busy, b_src_port, b_done}
                        !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
                        n_err++;
                        $display("FAIL %s abort k=%0d: got A ab=%b en=%b req=%b busy=%b port=%0d done=%b B ab=%b en=%b req=%b busy=%b port=%0d done=%b, want ab=1 rest 0",
                                 nm, k, a_aborted, a_src_en, a_meas_req, a_busy, a_src_port, a_done,
                                 b_aborted, b_src_en, b_meas_req, b_busy, b_src_port, b_done);
                    end
                    tick();
                    n_cmp++;
                    if ({a_aborted, a_done, a_busy, b_aborted, b_done, b_busy} !== 6'b0) begin
                        n_err++;
                        $display("FAIL %s post-abort: got A ab=%b done=%b busy=%b B ab=%b done=%b busy=%b, want all 0",
                                 nm, a_aborted, a_done, a_busy, b_aborted, b_done, b_busy);
                    end
                    return;
                end
            end
            meas_ack = 1'b0;
            tick();
            n_cmp++;
            if ({a_meas_req, b_meas_req, a_src_port, a_src_freq, b_src_port, b_src_freq}
                !== {2'b11, 3'(ap), fa, 3'(bp), fb}) begin
                n_err++;
                $display("FAIL %s req rise k=%0d: got reqA=%b reqB=%b A(%0d,%h) B(%0d,%h), want req=1 A(%0d,%h) B(%0d,%h)",
                         nm, k, a_meas_req, b_meas_req, a_src_port, a_src_freq, b_src_port, b_src_freq, ap, fa, bp, fb);
            end
            for (int j = 0; j < ack_lo; j++) begin
                start = 1'($urandom_range(0, 1));
                tick();
                start = 1'b0;
                n_cmp++;
                if ({a_meas_req, b_meas_req, a_busy, b_busy} !== 4'b1111) begin
                    n_err++;
                    $display("FAIL %s req hold k=%0d j=%0d: got reqA=%b reqB=%b busyA=%b busyB=%b, want 1111",
                             nm, k, j, a_meas_req, b_meas_req, a_busy, b_busy);
                end
            end
            meas_ack = 1'b1;
            tick();
            meas_ack = 1'b0;
            n_cmp++;
            if ({a_meas_req, b_meas_req, a_busy, b_busy, a_src_en, b_src_en} !== 6'b001111) begin
                n_err++;
                $display("FAIL %s req drop k=%0d: got reqA=%b reqB=%b busyA=%b busyB=%b enA=%b enB=%b, want req=0 busy=1 en=1",
                         nm, k, a_meas_req, b_meas_req, a_busy, b_busy, a_src_en, b_src_en);
            end
            tick();
        end
        n_cmp++;
        if ({a_src_en, a_busy, a_meas_req, a_src_port, a_done, b_src_en, b_busy, b_meas_req, b_src_port, b_done} !== '0) begin
            n_err++;
            $display("FAIL %s finish: got A en=%b busy=%b req=%b port=%0d done=%b B en=%b busy=%b req=%b port=%0d done=%b, want all 0",
                     nm, a_src_en, a_busy, a_meas_req, a_src_port, a_done, b_src_en, b_busy, b_meas_req, b_src_port, b_done);
        end
        tick();
        n_cmp++;
        if ({a_done, b_done, a_busy, b_busy, a_aborted, b_aborted} !== 6'b110000) begin
            n_err++;
            $display("FAIL %s done pulse: got doneA=%b doneB=%b busyA=%b busyB=%b abA=%b abB=%b, want done=1 rest 0",
                     nm, a_done, b_done, a_busy, b_busy, a_aborted, b_aborted);
        end
        tick();
        n_cmp++;
        if ({a_done, b_done} !== 2'b00) begin
            n_err++;
            $display("FAIL %s done width: got doneA=%b doneB=%b, want 0", nm, a_done, b_done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({a_src_freq, a_src_port, a_src_en, a_meas_req, a_point_idx, a_busy, a_done, a_aborted, a_freq_ovf,
             b_src_freq, b_src_port, b_src_en, b_meas_req, b_point_idx, b_busy, b_done, b_aborted, b_freq_ovf} !== '0) begin
            n_err++;
            $display("FAIL reset: got A f=%h p=%0d en=%b req=%b i=%0d busy=%b ovf=%b B f=%h p=%0d en=%b, want all 0",
                     a_src_freq, a_src_port, a_src_en, a_meas_req, a_point_idx, a_busy, a_freq_ovf, b_src_freq, b_src_port, b_src_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({a_src_en, a_busy, a_done, a_meas_req, b_src_en, b_busy, b_done, b_meas_req} !== 8'b0) begin
            n_err++;
            $display("FAIL idle after reset: got A en=%b busy=%b done=%b req=%b B en=%b busy=%b done=%b req=%b, want 0",
                     a_src_en, a_busy, a_done, a_meas_req, b_src_en, b_busy, b_done, b_meas_req);
        end
    endtask

    task automatic test_loop_order();
        run_sweep("order", 32'd1_000_000_000, 32'd1_000_000, 3, 2, 0, 1, -1, 0);
    endtask

    task automatic test_settle_hold();
        run_sweep("settle", 32'd2_000_000, 32'd500, 1, 1, 5, 10, -1, 0);
    endtask

    task automatic test_zero_points_and_clamp();
        f_start = 32'd1234; f_step = 32'd1; n_points = 16'd0; n_ports = 3'd3; settle_cycles = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({a_src_en, a_meas_req, a_busy, a_done, b_src_en, b_meas_req, b_busy, b_done} !== 8'b0) begin
            n_err++;
            $display("FAIL zero pts c1: got A en=%b req=%b busy=%b done=%b B en=%b req=%b busy=%b done=%b, want 0",
                     a_src_en, a_meas_req, a_busy, a_done, b_src_en, b_meas_req, b_busy, b_done);
        end
        tick();
        n_cmp++;
        if ({a_done, b_done, a_meas_req, b_meas_req, a_src_en, b_src_en} !== 6'b110000) begin
            n_err++;
            $display("FAIL zero pts c2: got doneA=%b doneB=%b reqA=%b reqB=%b enA=%b enB=%b, want done=1 rest 0",
                     a_done, b_done, a_meas_req, b_meas_req, a_src_en, b_src_en);
        end
        tick();
        n_cmp++;
        if ({a_done, b_done, a_meas_req, b_meas_req} !== 4'b0) begin
            n_err++;
            $display("FAIL zero pts c3: got doneA=%b doneB=%b reqA=%b reqB=%b, want 0", a_done, b_done, a_meas_req, b_meas_req);
        end
        run_sweep("clamp7", 32'd77_000, 32'd3_000, 2, 7, 1, 0, -1, 0);
        run_sweep("ports0", 32'd10, 32'd20, 3, 0, 0, 0, -1, 0);
    endtask

    task automatic test_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({a_aborted, b_aborted, a_busy, b_busy} !== 4'b0) begin
            n_err++;
            $display("FAIL idle abort: got abA=%b abB=%b busyA=%b busyB=%b, want 0", a_aborted, b_aborted, a_busy, b_busy);
        end
        run_sweep("abort", 32'd1_000_000_000, 32'd1_000_000, 3, 2, 4, 1, 2, 1);
        repeat (2) tick();
        n_cmp++;
        if ({a_done, b_done, a_busy, b_busy} !== 4'b0) begin
            n_err++;
            $display("FAIL abort no-done: got doneA=%b doneB=%b busyA=%b busyB=%b, want 0", a_done, b_done, a_busy, b_busy);
        end
        run_sweep("restart", 32'd1_000_000_000, 32'd1_000_000, 3, 2, 1, 0, -1, 0);
    endtask

    task automatic test_overflow();
        run_sweep("ovf", 32'hFFFF_FFF0, 32'h0000_0010, 2, 1, 0, 0, -1, 0);
        repeat (3) tick();
        n_cmp++;
        if ({a_freq_ovf, b_freq_ovf} !== 2'b11) begin
            n_err++;
            $display("FAIL ovf sticky: got ovfA=%b ovfB=%b, want 1", a_freq_ovf, b_freq_ovf);
        end
        run_sweep("ovf clear", 32'd100, 32'd1, 2, 1, 0, 0, -1, 0);
    endtask

    task automatic test_async_reset();
        f_start = 32'd5; f_step = 32'd3; n_points = 16'd2; n_ports = 3'd2; settle_cycles = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if ({a_meas_req, b_meas_req} !== 2'b11) begin
            n_err++;
            $display("FAIL pre-reset measure: got reqA=%b reqB=%b, want 1", a_meas_req, b_meas_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_src_freq, a_src_port, a_src_en, a_meas_req, a_point_idx, a_busy, a_done, a_aborted, a_freq_ovf,
             b_src_freq, b_src_port, b_src_en, b_meas_req, b_point_idx, b_busy, b_done, b_aborted, b_freq_ovf} !== '0) begin
            n_err++;
            $display("FAIL async reset: got A f=%h p=%0d en=%b req=%b i=%0d busy=%b B f=%h p=%0d en=%b req=%b, want all 0",
                     a_src_freq, a_src_port, a_src_en, a_meas_req, a_point_idx, a_busy, b_src_freq, b_src_port, b_src_en, b_meas_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int np, npo, st, al, ak, ad, eff;
        logic [31:0] fs, fst;
        for (int it = 0; it < 8; it++) begin
            np  = $urandom_range(1, 4);
            npo = $urandom_range(0, 7);
            st  = $urandom_range(0, 3);
            al  = $urandom_range(0, 3);
            fs  = $urandom;
            fst = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
            eff = (npo < 1) ? 1 : ((npo > MAXP) ? MAXP : npo);
            ak  = -1;
            ad  = 0;
            if (st > 0 && $urandom_range(0, 3) == 0) begin
                ak = $urandom_range(0, np * eff - 1);
                ad = $urandom_range(0, st - 1);
            end
            run_sweep("random", fs, fst, np, npo, st, al, ak, ad);
            repeat (2) tick();
        end
    endtask

    initial begin
        test_reset();
        test_loop_order();
        test_settle_hold();
        test_zero_points_and_clamp();
        test_abort();
        test_overflow();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
